shift_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 16-bit registered arithmetic right shifter. It accepts shift requests over valid/ready handshakes, drives the shifter's operand and amount inputs, and waits out the shifter's one-clock register latency. It captures the result and returns it with the requester's ID over a held valid/ready response channel. It sits between the two datapath clients and the single shifter instance, which is a clocked block with no enable or reset.

---
 rtl/shift_arbiter.sv | 140 ++++++++++++++
 tb/tb_shift_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing one 16-bit registered
// arithmetic right shifter; walks each operation through IDLE/SHIFT/LOAD/RESP.
module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [3:0]  req0_amt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [3:0]  req1_amt,
  output logic        req1_ready,
  output logic [15:0] sh_a,
  output logic [3:0]  sh_amt,
  input  logic [15:0] sh_r,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] sh_a_q, sh_a_d;
  logic [3:0]  sh_amt_q, sh_amt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        gnt_any_s;
  logic        gnt_id_s;

  // Grant selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = 1'b0;
      end else if (req1_valid) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = 1'b1;
      end else begin
        gnt_any_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    end else begin
      gnt_any_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  // Ready is suppressed while reset is held so nothing is accepted into an aborted state.
  assign req0_ready = gnt_any_s && (gnt_id_s == 1'b0) && !rst;
  assign req1_ready = gnt_any_s && (gnt_id_s == 1'b1) && !rst;

  // Next-state and datapath-register update for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sh_a_d       = sh_a_q;
    sh_amt_d     = sh_amt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          sh_a_d       = gnt_id_s ? req1_a : req0_a;
          sh_amt_d     = gnt_id_s ? req1_amt : req0_amt;
          rsp_id_d     = gnt_id_s;
          last_grant_d = gnt_id_s;
          state_d      = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Shifter output now reflects the operands captured at the end of SHIFT.
        rsp_data_d  = sh_r;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that also aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      sh_a_q       <= 16'h0000;
      sh_amt_q     <= 4'h0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sh_a_q       <= sh_a_d;
      sh_amt_q     <= sh_amt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign sh_a      = sh_a_q;
  assign sh_amt    = sh_amt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural registered shifter
// closing the sh_a/sh_amt -> sh_r loop.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req1_a;
  logic [3:0]  req0_amt, req1_amt;
  logic        req0_ready, req1_ready;
  logic [15:0] sh_a;
  logic [3:0]  sh_amt;
  logic [15:0] sh_r = 16'h0000;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Shared shifter: registered, no enable, no reset.
  always_ff @(posedge clk) sh_r <= 16'($signed(sh_a) >>> sh_amt);

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_r(sh_r),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'h0000);
    check({tag, "_sh_a"}, {16'd0, sh_a}, 32'h0000);
    check({tag, "_sh_amt"}, {28'd0, sh_amt}, 32'h0);
  endtask

  // One complete operation: accept, 3-edge latency, then consume the response.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [3:0] amt,
                       input logic [15:0] exp_data, input string tag);
    int n;
    logic rdy;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_amt = amt; end
    else begin req0_valid = 1'b1; req0_a = a; req0_amt = amt; end
    #1;
    n = 0;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      cyc();
      #1;
      n++;
      rdy = id ? req1_ready : req0_ready;
    end
    check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    check({tag, "_other_ready"}, {31'd0, (id ? req0_ready : req1_ready)}, 32'd0);
    cyc();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    check({tag, "_ready_drop"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd0);
    check({tag, "_sh_a"}, {16'd0, sh_a}, {16'd0, a});
    check({tag, "_sh_amt"}, {28'd0, sh_amt}, {28'd0, amt});
    check({tag, "_vld_e1"}, {31'd0, rsp_valid}, 32'd0);
    cyc();
    check({tag, "_vld_e2"}, {31'd0, rsp_valid}, 32'd0);
    cyc();
    check({tag, "_vld_e3"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_data});
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check({tag, "_vld_done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h8000; req0_amt = 4'd4;
    req1_valid = 1'b0; req1_a = 16'h0000; req1_amt = 4'd0;
    cyc(); cyc();
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_reset_vals("rst");
    rst = 1'b0; req0_valid = 1'b0;
    cyc();

    // Basic operations and amount boundaries
    do_op(1'b0, 16'h8000, 4'd4, 16'hF800, "op0_8000_4");
    do_op(1'b1, 16'h7F00, 4'd8, 16'h007F, "op1_7F00_8");
    do_op(1'b1, 16'h8100, 4'd8, 16'hFF81, "op1_8100_8");
    do_op(1'b0, 16'h1234, 4'd0, 16'h1234, "amt0");
    do_op(1'b0, 16'h8000, 4'd15, 16'hFFFF, "amt15_neg");
    do_op(1'b1, 16'h7FFF, 4'd15, 16'h0000, "amt15_pos");

    // Both requesters valid from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0F00; req0_amt = 4'd4;
    req1_valid = 1'b1; req1_a = 16'hF000; req1_amt = 4'd4;
    cyc();
    #1;
    check("tie_rst_r1", {31'd0, req1_ready}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_idle_r0", {31'd0, req0_ready}, {31'd0, (k % 2 == 0)});
      check("tie_idle_r1", {31'd0, req1_ready}, {31'd0, (k % 2 == 1)});
      cyc();
      check("tie_shift_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("tie_shift_vld", {31'd0, rsp_valid}, 32'd0);
      cyc();
      check("tie_load_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      cyc();
      check("tie_resp_vld", {31'd0, rsp_valid}, 32'd1);
      check("tie_resp_id", {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check("tie_resp_data", {16'd0, rsp_data}, (k % 2 == 0) ? 32'h00F0 : 32'hFF00);
      check("tie_resp_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    cyc();

    // Backpressure: response held 10 cycles, pending req1 waits
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_amt = 4'd2;
    #1;
    check("bp_acc0", {31'd0, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_amt = 4'd1;
    #1;
    check("bp_shift_r1", {31'd0, req1_ready}, 32'd0);
    cyc(); cyc();
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_vld", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_id", {31'd0, rsp_id}, 32'd0);
      check("bp_hold_data", {16'd0, rsp_data}, 32'h003F);
      check("bp_hold_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_vld", {31'd0, rsp_valid}, 32'd1);
    check("bp_hs_r1", {31'd0, req1_ready}, 32'd0);
    cyc();
    rsp_ready = 1'b0;
    check("bp_after_vld", {31'd0, rsp_valid}, 32'd0);
    check("bp_after_r1", {31'd0, req1_ready}, 32'd1);
    do_op(1'b1, 16'h8000, 4'd1, 16'hC000, "bp_req1");

    // Reset during LOAD aborts the operation
    req0_valid = 1'b1; req0_a = 16'h4000; req0_amt = 4'd2;
    #1;
    check("abort_acc", {31'd0, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    check_reset_vals("abort");
    check("abort_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_op(1'b0, 16'h4000, 4'd2, 16'h1000, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
